sram_ctrl: RTL



---
 rtl/sram_ctrl_pkg.sv | 28 ++
 rtl/sram_ctrl_beat_timer.sv | 36 +++
 rtl/sram_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and helpers for the external-SRAM controller.
// Contents: FSM state enum, beat-count helpers, data-slice index helper.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Number of SRAM beats per core word.
    function automatic int unsigned calc_beats(input int unsigned bus_w, input int unsigned mem_w);
        return bus_w / mem_w;
    endfunction

    // Beat index width (log2 of the beat count).
    function automatic int unsigned calc_bb(input int unsigned beats);
        return $clog2(beats);
    endfunction

    // LSB of the data slice for a beat; beat 0 is the most-significant slice.
    function automatic int unsigned slice_lo(input int unsigned bus_w, input int unsigned mem_w,
                                             input int unsigned beat);
        return bus_w - (beat + 1) * mem_w;
    endfunction

endpackage

// File: rtl/sram_ctrl_beat_timer.sv
// sram_ctrl_beat_timer: per-beat wait-state down-counter.
// Ports: clk, rst (sync, active-high), load (restart at WAIT_CYC),
//        done_c (count has reached zero; last strobe cycle of the beat).
module sram_ctrl_beat_timer #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done_c
);
    localparam int unsigned CW = 4;

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload on beat start, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(WAIT_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: splits core word accesses into BUS_W/MEM_W SRAM beats.
// Core side : req_valid/req_ready handshake, req_we/addr/wdata/be, rsp_valid pulse + rsp_rdata.
// SRAM side : mem_cs, mem_re_n, mem_we_n, mem_be_n, mem_addr={addr,beat}, mem_wdata, mem_rdata.
// All mem_* and rsp_* outputs are registered and lag the FSM state by one cycle.
// Option: define SRAM_CTRL_BE_SKIP_EN to skip store beats whose byte enables are all zero.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BUS_W    = 32,
    parameter int unsigned MEM_W    = 16,
    parameter int unsigned ADDR_W   = 23,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [BUS_W-1:0]         req_wdata,
    input  logic [BUS_W/8-1:0]       req_be,
    output logic                     rsp_valid,
    output logic [BUS_W-1:0]         rsp_rdata,
    output logic                     mem_cs,
    output logic                     mem_re_n,
    output logic                     mem_we_n,
    output logic [MEM_W/8-1:0]       mem_be_n,
    output logic [ADDR_W+calc_bb(calc_beats(BUS_W, MEM_W))-1:0] mem_addr,
    output logic [MEM_W-1:0]         mem_wdata,
    input  logic [MEM_W-1:0]         mem_rdata
);
    localparam int unsigned BEATS = calc_beats(BUS_W, MEM_W);
    localparam int unsigned BB    = calc_bb(BEATS);
    localparam int unsigned BBW   = (BB == 0) ? 1 : BB;
    localparam int unsigned BEW   = BUS_W / 8;
    localparam int unsigned MBW   = MEM_W / 8;
    localparam int unsigned MAW   = ADDR_W + BB;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BUS_W-1:0]    wdata_q, wdata_d;
    logic [BEW-1:0]      be_q, be_d;
    logic [BBW-1:0]      beat_q, beat_d;
    logic                cap_q, cap_d;
    logic [BBW-1:0]      cap_beat_q, cap_beat_d;
    logic [BUS_W-1:0]    rbuf_q, rbuf_d;

    logic                rsp_valid_q, rsp_valid_d;
    logic [BUS_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                mem_cs_q, mem_cs_d;
    logic                mem_re_n_q, mem_re_n_d;
    logic                mem_we_n_q, mem_we_n_d;
    logic [MBW-1:0]      mem_be_n_q, mem_be_n_d;
    logic [MAW-1:0]      mem_addr_q, mem_addr_d;
    logic [MEM_W-1:0]    mem_wdata_q, mem_wdata_d;

    logic                tmr_load_c;
    logic                tmr_done_c;
    logic [BEATS-1:0]    en_req_c, en_cur_c;
    logic                first_found_c, next_found_c;
    logic [BBW-1:0]      first_beat_c, next_beat_c;
    logic [MEM_W-1:0]    wslice_c;
    logic [MBW-1:0]      bslice_c;
    logic [ADDR_W+BBW-1:0] addr_cat_c;

    sram_ctrl_beat_timer #(
        .WAIT_CYC (WAIT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load_c),
        .done_c (tmr_done_c)
    );

    // Per-beat enables: with skipping, a store beat with no enabled bytes is dropped.
    always_comb begin
        en_req_c = '1;
        en_cur_c = '1;
`ifdef SRAM_CTRL_BE_SKIP_EN
        for (int unsigned b = 0; b < BEATS; b++) begin
            en_req_c[b] = !req_we || (|req_be[slice_lo(BUS_W, MEM_W, b)/8 +: MBW]);
            en_cur_c[b] = !we_q   || (|be_q[slice_lo(BUS_W, MEM_W, b)/8 +: MBW]);
        end
`endif
    end

    // First enabled beat of a new request, and next enabled beat after the current one.
    always_comb begin
        first_found_c = 1'b0;
        first_beat_c  = '0;
        next_found_c  = 1'b0;
        next_beat_c   = '0;
        for (int b = BEATS - 1; b >= 0; b--) begin
            if (en_req_c[b]) begin
                first_found_c = 1'b1;
                first_beat_c  = BBW'(b);
            end
            if (en_cur_c[b] && (BBW'(b) > beat_q)) begin
                next_found_c = 1'b1;
                next_beat_c  = BBW'(b);
            end
        end
    end

    // Current-beat write data / byte-enable slices and load-data assembly.
    always_comb begin
        wslice_c = '0;
        bslice_c = '0;
        rbuf_d   = rbuf_q;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat_q == BBW'(b)) begin
                wslice_c = wdata_q[slice_lo(BUS_W, MEM_W, b) +: MEM_W];
                bslice_c = be_q[slice_lo(BUS_W, MEM_W, b)/8 +: MBW];
            end
            // mem_rdata reflects last cycle's strobes, so capture one cycle after the beat ends.
            if (cap_q && (cap_beat_q == BBW'(b))) begin
                rbuf_d[slice_lo(BUS_W, MEM_W, b) +: MEM_W] = mem_rdata;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        beat_d     = beat_q;
        tmr_load_c = 1'b0;
        cap_d      = 1'b0;
        cap_beat_d = beat_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    beat_d  = first_beat_c;
                    if (first_found_c) begin
                        tmr_load_c = 1'b1;
                        state_d    = ACCESS;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                if (tmr_done_c) begin
                    cap_d = !we_q;
                    if (next_found_c) begin
                        beat_d  = next_beat_c;
                        state_d = GAP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            GAP: begin
                tmr_load_c = 1'b1;
                state_d    = ACCESS;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign addr_cat_c = {addr_q, beat_q};

    // Registered outputs; address/data/be only update in ACCESS so they hold through GAP and IDLE.
    always_comb begin
        rsp_valid_d = (state_q == DONE);
        rsp_rdata_d = rsp_rdata_q;
        if (state_q == DONE) begin
            rsp_rdata_d = we_q ? '0 : rbuf_d;
        end
        mem_cs_d    = (state_q == ACCESS) || (state_q == GAP);
        mem_re_n_d  = !((state_q == ACCESS) && !we_q);
        mem_we_n_d  = !((state_q == ACCESS) && we_q);
        mem_addr_d  = mem_addr_q;
        mem_be_n_d  = mem_be_n_q;
        mem_wdata_d = mem_wdata_q;
        if (state_q == ACCESS) begin
            mem_addr_d = MAW'(addr_cat_c >> (BBW - BB));
            mem_be_n_d = we_q ? ~bslice_c : '0;
            if (we_q) begin
                mem_wdata_d = wslice_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            beat_q      <= '0;
            cap_q       <= 1'b0;
            cap_beat_q  <= '0;
            rbuf_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_cs_q    <= 1'b0;
            mem_re_n_q  <= 1'b1;
            mem_we_n_q  <= 1'b1;
            mem_be_n_q  <= '1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            beat_q      <= beat_d;
            cap_q       <= cap_d;
            cap_beat_q  <= cap_beat_d;
            rbuf_q      <= rbuf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_re_n_q  <= mem_re_n_d;
            mem_we_n_q  <= mem_we_n_d;
            mem_be_n_q  <= mem_be_n_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_cs    = mem_cs_q;
    assign mem_re_n  = mem_re_n_q;
    assign mem_we_n  = mem_we_n_q;
    assign mem_be_n  = mem_be_n_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
